// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: arbitrates one event per
// decision, strobes the CP0 commit, flushes the front end, then redirects the PC.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic [31:0] mem_fetch_va,
  input  logic [31:0] mem_data_va,
  input  logic        mem_eret,
  input  logic [31:0] status_value,
  input  logic [31:0] cause_value,
  input  logic [31:0] epc_value,
  output logic        trap,
  output logic        eret,
  output logic [4:0]  excode,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic        badvaddr_wen,
  output logic [31:0] badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        r_trap, w_trap_nxt;
  logic        r_eret, w_eret_nxt;
  logic [4:0]  r_excode, w_excode_nxt;
  logic        r_bd, w_bd_nxt;
  logic [31:0] r_epc, w_epc_nxt;
  logic        r_bwen, w_bwen_nxt;
  logic [31:0] r_bva, w_bva_nxt;
  logic        r_flush, w_flush_nxt;
  logic        r_rv, w_rv_nxt;
  logic [31:0] r_rpc, w_rpc_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_int_pend;
  logic        w_exc_any;
  logic        w_fetch_err;
  logic [4:0]  w_code;
  logic        w_unused;

  assign w_int_pend = status_value[0] & ~status_value[1] &
                      (|(cause_value[15:8] & status_value[15:8]));
  assign w_unused   = ^{status_value[31:16], status_value[7:2],
                        cause_value[31:16], cause_value[7:0]};

  // Fixed-priority pick; interrupt outranks every synchronous exception.
  always_comb begin
    w_exc_any   = 1'b1;
    w_fetch_err = 1'b0;
    w_code      = 5'd0;
    if (w_int_pend)      w_code = 5'd0;
    else if (mem_exc[0]) begin w_code = 5'd4; w_fetch_err = 1'b1; end
    else if (mem_exc[1]) w_code = 5'd10;
    else if (mem_exc[2]) w_code = 5'd12;
    else if (mem_exc[3]) w_code = 5'd8;
    else if (mem_exc[4]) w_code = 5'd9;
    else if (mem_exc[5]) w_code = 5'd4;
    else if (mem_exc[6]) w_code = 5'd5;
    else                 w_exc_any = 1'b0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_trap_nxt   = 1'b0;
    w_eret_nxt   = 1'b0;
    w_excode_nxt = r_excode;
    w_bd_nxt     = r_bd;
    w_epc_nxt    = r_epc;
    w_bwen_nxt   = 1'b0;
    w_bva_nxt    = r_bva;
    w_flush_nxt  = 1'b0;
    w_rv_nxt     = 1'b0;
    w_rpc_nxt    = r_rpc;
    w_busy_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid && (w_exc_any || mem_eret)) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = 4'(FLUSH_CYCLES - 1);
          w_flush_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          if (w_exc_any) begin
            w_trap_nxt   = 1'b1;
            w_excode_nxt = w_code;
            w_bd_nxt     = mem_bd;
            w_epc_nxt    = mem_bd ? (mem_pc - 32'd4) : mem_pc;
            w_bwen_nxt   = (w_code == 5'd4) || (w_code == 5'd5);
            w_bva_nxt    = w_fetch_err ? mem_fetch_va : mem_data_va;
            w_target_nxt = EXC_VECTOR;
          end else begin
            w_eret_nxt   = 1'b1;
            w_target_nxt = epc_value;
          end
        end
      end
      S_FLUSH: begin
        w_flush_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_REDIRECT;
          w_rv_nxt    = 1'b1;
          w_rpc_nxt   = r_target;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_trap   <= 1'b0;
      r_eret   <= 1'b0;
      r_excode <= '0;
      r_bd     <= 1'b0;
      r_epc    <= '0;
      r_bwen   <= 1'b0;
      r_bva    <= '0;
      r_flush  <= 1'b0;
      r_rv     <= 1'b0;
      r_rpc    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_trap   <= w_trap_nxt;
      r_eret   <= w_eret_nxt;
      r_excode <= w_excode_nxt;
      r_bd     <= w_bd_nxt;
      r_epc    <= w_epc_nxt;
      r_bwen   <= w_bwen_nxt;
      r_bva    <= w_bva_nxt;
      r_flush  <= w_flush_nxt;
      r_rv     <= w_rv_nxt;
      r_rpc    <= w_rpc_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign trap           = r_trap;
  assign eret           = r_eret;
  assign excode         = r_excode;
  assign exc_bd         = r_bd;
  assign exc_epc        = r_epc;
  assign badvaddr_wen   = r_bwen;
  assign badvaddr       = r_bva;
  assign flush          = r_flush;
  assign redirect_valid = r_rv;
  assign redirect_pc    = r_rpc;
  assign busy           = r_busy;
endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected commits/redirects are queued at issue
// time and consumed by a monitor when the DUT strobes.
module tb_exc_ctrl;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_bd, mem_eret;
  logic [31:0] mem_pc, mem_fetch_va, mem_data_va;
  logic [6:0]  mem_exc;
  logic [31:0] status_value, cause_value, epc_value;
  logic        trap, eret, exc_bd, badvaddr_wen, flush, redirect_valid, busy;
  logic [4:0]  excode;
  logic [31:0] exc_epc, badvaddr, redirect_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_trap;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        bwen;
    logic [31:0] bva;
    logic [31:0] tgt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rq[$];
  exp_t        m_e;
  logic [31:0] m_t;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .mem_exc(mem_exc), .mem_fetch_va(mem_fetch_va), .mem_data_va(mem_data_va),
    .mem_eret(mem_eret), .status_value(status_value), .cause_value(cause_value),
    .epc_value(epc_value), .trap(trap), .eret(eret), .excode(excode), .exc_bd(exc_bd),
    .exc_epc(exc_epc), .badvaddr_wen(badvaddr_wen), .badvaddr(badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  function automatic exp_t mk(bit t, logic [4:0] c, logic bd, logic [31:0] epc,
                              logic bw, logic [31:0] bva, logic [31:0] tgt);
    exp_t e;
    e.is_trap = t; e.code = c; e.bd = bd; e.epc = epc; e.bwen = bw; e.bva = bva; e.tgt = tgt;
    return e;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (trap && eret) begin
        checks++; failures++;
        $display("FAIL trap_eret_overlap trap=%b eret=%b required not both", trap, eret);
      end
      if (trap || eret) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe trap=%b eret=%b required none", trap, eret);
        end else begin
          m_e = exp_q.pop_front();
          if (trap !== m_e.is_trap) begin
            failures++;
            $display("FAIL strobe_kind trap=%b required trap=%b", trap, m_e.is_trap);
          end else if (m_e.is_trap) begin
            checks++;
            if (excode !== m_e.code || exc_bd !== m_e.bd || exc_epc !== m_e.epc ||
                badvaddr_wen !== m_e.bwen) begin
              failures++;
              $display("FAIL trap_fields code=%0d bd=%b epc=%h bwen=%b required code=%0d bd=%b epc=%h bwen=%b",
                       excode, exc_bd, exc_epc, badvaddr_wen, m_e.code, m_e.bd, m_e.epc, m_e.bwen);
            end
            if (m_e.bwen) begin
              checks++;
              if (badvaddr !== m_e.bva) begin
                failures++;
                $display("FAIL badvaddr got=%h required=%h", badvaddr, m_e.bva);
              end
            end
          end
        end
      end
      if (redirect_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_redirect pc=%h required no redirect", redirect_pc);
        end else begin
          m_t = rq.pop_front();
          if (redirect_pc !== m_t) begin
            failures++;
            $display("FAIL redirect_pc got=%h required=%h", redirect_pc, m_t);
          end
        end
      end
    end
  end

  // Present one MEM instruction for a single decision cycle; returns in T+1.
  task automatic issue(input logic [6:0] exc, input logic er, input logic [31:0] pc,
                       input logic bd, input logic [31:0] dva, input exp_t e, input bit push_rd);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = exc; mem_eret = er; mem_pc = pc; mem_bd = bd;
    mem_fetch_va = pc; mem_data_va = dva;
    exp_q.push_back(e);
    if (push_rd) rq.push_back(e.tgt);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_exc = '0; mem_eret = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 50);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout busy=%b required 0 within 50 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({trap, eret, flush, redirect_valid, busy, badvaddr_wen, exc_bd} !== 7'b0 ||
        excode !== 5'd0 || exc_epc !== 32'd0 || badvaddr !== 32'd0 || redirect_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_values strobes=%b excode=%0d epc=%h bva=%h rpc=%h required all zero",
               {trap, eret, flush, redirect_valid, busy, badvaddr_wen, exc_bd},
               excode, exc_epc, badvaddr, redirect_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_sys_timing();
    issue(7'b000_1000, 1'b0, 32'h80001000, 1'b0, 32'h0,
          mk(1, 5'd8, 1'b0, 32'h80001000, 1'b0, 32'h0, VEC), 1);
    for (int k = 1; k <= FC + 2; k++) begin
      @(negedge clk);
      checks++;
      if (flush !== (k <= FC + 1) || busy !== (k <= FC + 1) ||
          redirect_valid !== (k == FC + 1) || trap !== (k == 1)) begin
        failures++;
        $display("FAIL sys_timing T+%0d flush=%b busy=%b rv=%b trap=%b required %b %b %b %b",
                 k, flush, busy, redirect_valid, trap, k <= FC + 1, k <= FC + 1, k == FC + 1, k == 1);
      end
    end
    wait_idle();
  endtask

  task automatic test_addr_err();
    issue(7'b100_0000, 1'b0, 32'h80000010, 1'b1, 32'h00000003,
          mk(1, 5'd5, 1'b1, 32'h8000000c, 1'b1, 32'h00000003, VEC), 1);
    wait_idle();
    // fetch AdEL beats data AdES and reports the fetch address
    issue(7'b100_0001, 1'b0, 32'h80000401, 1'b0, 32'h12345678,
          mk(1, 5'd4, 1'b0, 32'h80000401, 1'b1, 32'h80000401, VEC), 1);
    wait_idle();
    // EPC wraps for a delay-slot instruction at address 0
    issue(7'b010_0000, 1'b0, 32'h00000000, 1'b1, 32'hdeadbeef,
          mk(1, 5'd4, 1'b1, 32'hfffffffc, 1'b1, 32'hdeadbeef, VEC), 1);
    wait_idle();
    issue(7'b001_0110, 1'b0, 32'h80000020, 1'b0, 32'h0,
          mk(1, 5'd10, 1'b0, 32'h80000020, 1'b0, 32'h0, VEC), 1);
    wait_idle();
  endtask

  task automatic test_interrupt();
    status_value = 32'h0000_0401; cause_value = 32'h0000_0400;
    issue(7'b000_0100, 1'b0, 32'h80003000, 1'b0, 32'h0,
          mk(1, 5'd0, 1'b0, 32'h80003000, 1'b0, 32'h0, VEC), 1);
    wait_idle();
    status_value = 32'h0000_0403;
    issue(7'b000_0100, 1'b0, 32'h80003004, 1'b0, 32'h0,
          mk(1, 5'd12, 1'b0, 32'h80003004, 1'b0, 32'h0, VEC), 1);
    wait_idle();
    // pending interrupt without a valid instruction must wait
    status_value = 32'h0000_0401;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || trap !== 1'b0) begin
        failures++;
        $display("FAIL int_no_valid busy=%b trap=%b required 0 0", busy, trap);
      end
    end
    status_value = 32'h0; cause_value = 32'h0;
  endtask

  task automatic test_eret();
    epc_value = 32'h80002000;
    issue(7'b000_1000, 1'b1, 32'h80000100, 1'b0, 32'h0,
          mk(1, 5'd8, 1'b0, 32'h80000100, 1'b0, 32'h0, VEC), 1);
    wait_idle();
    issue(7'b000_0000, 1'b1, 32'h80000104, 1'b0, 32'h0,
          mk(0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h80002000), 1);
    @(negedge clk);
    checks++;
    if (eret !== 1'b1 || trap !== 1'b0 || flush !== 1'b1) begin
      failures++;
      $display("FAIL eret_strobe eret=%b trap=%b flush=%b required 1 0 1", eret, trap, flush);
    end
    epc_value = 32'h0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int ntrap = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = 7'b000_1000; mem_pc = 32'h80004000; mem_bd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1, 5'd8, 1'b0, 32'h80004000, 1'b0, 32'h0, VEC));
      rq.push_back(VEC);
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 11) begin mem_valid = 1'b0; mem_exc = '0; end
      @(negedge clk);
      if (trap === 1'b1) ntrap++;
    end
    checks++;
    if (ntrap !== 3) begin
      failures++;
      $display("FAIL back_to_back traps=%0d required 3", ntrap);
    end
    wait_idle();
  endtask

  task automatic test_reset_abort();
    issue(7'b001_0000, 1'b0, 32'h80005000, 1'b0, 32'h0,
          mk(1, 5'd9, 1'b0, 32'h80005000, 1'b0, 32'h0, VEC), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({trap, eret, flush, redirect_valid, busy, badvaddr_wen} !== 6'b0 ||
        excode !== 5'd0 || exc_epc !== 32'd0 || redirect_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_abort strobes=%b excode=%0d epc=%h rpc=%h required all zero",
               {trap, eret, flush, redirect_valid, busy, badvaddr_wen}, excode, exc_epc, redirect_pc);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_redirect rv=%b busy=%b required 0 0", redirect_valid, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_bd = 1'b0; mem_eret = 1'b0; mem_exc = '0;
    mem_pc = '0; mem_fetch_va = '0; mem_data_va = '0;
    status_value = '0; cause_value = '0; epc_value = '0;
    test_reset();
    test_sys_timing();
    test_addr_err();
    test_interrupt();
    test_eret();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending_strobes=%0d pending_redirects=%0d required 0 0",
               exp_q.size(), rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer for the five-stage MIPS pipeline. It sits between the MEM stage and the cp0reg register file. Each cycle it arbitrates the exception flags, the pending-interrupt condition and `eret` of the instruction in MEM. It then drives the commit strobes into CP0 (`trap`, `eret`, ExcCode, EPC, BadVAddr) and runs a flush-then-redirect sequence on the front end. It is the initiator side of the `trap`/`eret`/`int` interface that cp0reg responds to.

## Interface
- `EXC_VECTOR`, default 32'hbfc00380: redirect target for every exception and interrupt (BEV=1).
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after commit. Legal range 1..15.

Ports:
- `clk`  in  1: clock; all state changes on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `mem_valid`  in  1: MEM stage holds a real instruction.
- `mem_pc`  in  32: PC of the MEM instruction.
- `mem_bd`  in  1: MEM instruction is in a branch delay slot.
- `mem_exc`  in  7: exception flags, bit0 AdEL-fetch, bit1 RI, bit2 Ov, bit3 Sys, bit4 Bp, bit5 AdEL-data, bit6 AdES.
- `mem_fetch_va`  in  32: faulting fetch address (this equals `mem_pc`).
- `mem_data_va`  in  32: faulting load/store address.
- `mem_eret`  in  1: MEM instruction is `eret`.
- `status_value`  in  32: CP0 Status, read combinationally.
- `cause_value`  in  32: CP0 Cause, read combinationally.
- `epc_value`  in  32: CP0 EPC, read combinationally.
- `trap`  out  1: one-cycle commit strobe to CP0 (sets EXL).
- `eret`  out  1: one-cycle strobe to CP0 (clears EXL).
- `excode`  out  5: ExcCode, valid with `trap`.
- `exc_bd`  out  1: BD bit, valid with `trap`.
- `exc_epc`  out  32: EPC value, valid with `trap`.
- `badvaddr_wen`  out  1: BadVAddr write strobe, asserted with `trap` on address errors only.
- `badvaddr`  out  32: BadVAddr value.
- `flush`  out  1: kill IF..MEM and block register/memory writes.
- `redirect_valid`  out  1: one-cycle PC load request.
- `redirect_pc`  out  32: PC to load.
- `busy`  out  1: high in any state other than IDLE.

## Operation
States: IDLE, FLUSH, REDIRECT. All outputs are registered.

Interrupt pending:
- `int_pend = status[0] & ~status[1] & |(cause[15:8] & status[15:8])`.

Decision is evaluated in IDLE only, and only when `mem_valid=1`. Priority, highest first, with ExcCode:
- Int = 0 (takes `int_pend`).
- AdEL-fetch = 4.
- RI = 10.
- Ov = 12.
- Sys = 8.
- Bp = 9.
- AdEL-data = 4.
- AdES = 5.
- `mem_eret` only when no exception and no interrupt is selected.

Exception taken:
- Next cycle `trap=1`, with `excode` per the priority list and `exc_bd=mem_bd`.
- `exc_epc = mem_bd ? mem_pc-4 : mem_pc`, computed modulo 2^32.
- `badvaddr_wen=1` only for code 4 or 5. `badvaddr` is `mem_fetch_va` for fetch AdEL and `mem_data_va` otherwise.
- Latched target is `EXC_VECTOR`.

Eret taken:
- Next cycle `eret=1`.
- Latched target is `epc_value` as sampled in the decision cycle.

On either event:
- The FSM enters FLUSH and `flush=1`.
- A 4-bit down-counter loads `FLUSH_CYCLES-1` and decrements each cycle.
- At count 0 the FSM moves to REDIRECT.

REDIRECT:
- `redirect_valid=1` for one cycle, with `redirect_pc` set to the latched target and `flush=1`.
- The FSM then returns to IDLE.

Other rules:
- In FLUSH and REDIRECT, all inputs are ignored. A new decision is possible on the first IDLE cycle.
- `mem_valid=0` in IDLE means no action, even when `int_pend=1`; the interrupt waits for a valid instruction.

## Timing
- Decision in cycle T (IDLE).
- `trap`/`eret` high in T+1 only, and `flush` rises in T+1.
- `flush` stays high T+1..T+FLUSH_CYCLES+1.
- `redirect_valid` is high in T+FLUSH_CYCLES+1.
- `busy` is high T+1..T+FLUSH_CYCLES+1.
- The earliest next decision is T+FLUSH_CYCLES+2.
- Reset values: state IDLE; `trap`, `eret`, `flush`, `redirect_valid`, `busy`, `badvaddr_wen` all 0; `excode=0`, `exc_bd=0`, `exc_epc=0`, `badvaddr=0`, `redirect_pc=0`, counter 0.
- `rst` in any state: on the next edge, state is IDLE and all outputs hold their reset values. No pending redirect survives reset.

Simultaneous events:
- Exception and `mem_eret` together: the exception wins and no `eret` is issued.
- Several flags together: the highest priority wins, and only one `trap` is issued.
- `trap` and `eret` are never high in the same cycle.

## Test plan
- Sys at `mem_pc`=0x80001000, `mem_bd=0`, FLUSH_CYCLES=2 -> T+1: `trap=1`, `excode=8`, `exc_epc=0x80001000`, `badvaddr_wen=0`. `flush` is high T+1..T+3, and T+3 has `redirect_valid=1` with `redirect_pc=0xbfc00380`.
- AdES with `mem_data_va`=0x00000003, `mem_bd=1`, `mem_pc`=0x80000010 -> `excode=5`, `exc_bd=1`, `exc_epc=0x8000000c`, `badvaddr_wen=1`, `badvaddr=0x00000003`.
- Status=0x0000_0401 (IM2 set, IE set, EXL clear), Cause=0x0000_0400, Ov also set -> `excode=0` (Int beats Ov). Same stimulus with Status EXL=1 -> `excode=12`.
- `mem_eret` with `epc_value`=0x80002000, Sys also set -> `trap`, `excode=8`, no `eret`. `mem_eret` alone -> `eret=1` at T+1, `redirect_pc=0x80002000`.
- Exceptions presented on every cycle -> exactly one `trap` per FLUSH_CYCLES+2 cycles. Inputs during `busy` produce no extra strobe.
- `rst` asserted in T+2 (mid-FLUSH) -> T+3: all outputs 0, IDLE. No `redirect_valid` is ever produced for the aborted event.
